mc_accum_ctrl_hs: RTL and testbench
===================================

// Module: mc_accum_ctrl_hs
// PURPOSE
//  Multi-cycle control FSM for the 8-bit accumulator CPU, successor to the fixed controller.
//  Adds a parametrised accumulator file for reg-reg ops and a req/ready memory handshake with wait states.
//  Adds a HALT state with a halted flag. Decodes ir/czn and drives every datapath enable; sits between IR/flags and the datapath.
// PARAMETERS
//  ACC_SEL_W  2  accumulator index width (1..4); register file = 2**ACC_SEL_W accumulators
//  MEM_HS     1  1: memory accesses wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          reset, asynchronous, active-high
//  start       in   1          start request; a run begins on its falling edge
//  ir          in   8          current instruction register
//  czn         in   3          flags {C,Z,N}
//  mem_ready   in   1          memory completes the current access this cycle
//  done        out  1          controller in IDLE
//  busy        out  1          in any state except IDLE/HALT
//  halted      out  1          in HALT
//  mem_req     out  1          memory access request
//  mem_we      out  1          write qualifier for mem_req
//  addr_sel    out  1          memory address: 0 = PC, 1 = TR
//  pc_inc      out  1          PC <= PC+1
//  pc_ld       out  1          PC <= TR
//  ir_we       out  1          IR <= mem data
//  tr_we       out  1          TR <= mem data
//  a_we        out  1          A <= mem data (memory ops) or acc[acc_sel] (reg ops)
//  b_we        out  1          B <= acc[0]
//  a_zero      out  1          ALU A operand forced to 0
//  b_zero      out  1          ALU B operand forced to 0
//  alu_op      out  2          00 add, 01 sub, 10 and
//  alu_we      out  1          RES <= ALU output
//  czn_we      out  1          flags <= ALU flags
//  acc_we      out  1          acc[0] <= RES
//  acc_sel     out  ACC_SEL_W  A-port register index; 0 unless in RDREG
// BEHAVIOUR
//  - Decode classes:
//    - ir[7]=0: memory op, ir[6:5] = 00 LDA, 01 STA, 10 ADD, 11 SUB.
//    - ir[7:6]=10: reg op on acc[ir[ACC_SEL_W-1:0]], ir[5:4] = 00 MOV, 01 ADD, 10 SUB, 11 AND.
//    - ir[7:5]=110: jump, ir[2:1] = 00 always, 01 C, 10 Z, 11 N.
//    - ir[7:5]=111: ir[0]=1 HALT, else NOP.
//  - Outputs are combinational from state/ir/czn/mem_ready; every output not listed for a state is 0.
//  - rst async: state <= IDLE; outputs at once: done=1, all others 0. Valid mid-access; mem_req drops immediately.
//  - Handshake: a mem state holds mem_req (and addr_sel/mem_we) until mem_ready=1.
//    Capture enables (ir_we, tr_we, a_we, pc_inc) pulse only in the accept cycle.
//    Leaving the state happens on the next edge after accept. mem_ready without mem_req is ignored.
//  - FSM (Moore states, zero-wait cycle counts):
//    - IDLE: done=1; start=1 -> START.
//    - START: start=0 -> FETCH.
//    - FETCH: mem_req, addr 0; accept: ir_we, pc_inc -> DECODE.
//    - DECODE: mem op/jump -> OPFETCH; reg op -> RDREG; NOP -> FETCH; HALT -> HALT.
//    - OPFETCH: mem_req, addr 0; accept: tr_we, pc_inc -> jump ? BRANCH : LDOPS.
//    - LDOPS: b_we; LDA/ADD/SUB: mem_req, addr 1, a_we on accept; STA: no mem, 1 cycle -> EXEC.
//    - RDREG: acc_sel=ir index, a_we, b_we -> EXEC.
//    - EXEC: alu_we; memory ops: LDA b_zero + czn_we, STA a_zero, ADD czn_we, SUB op01 + czn_we.
//      Reg ops: MOV b_zero, ADD/SUB/AND op 00/01/10 + czn_we -> WB.
//    - WB: STA: mem_req, mem_we, addr 1 until accept; others: acc_we one cycle -> FETCH.
//    - BRANCH: pc_ld = cond true (always, czn[2], czn[1], czn[0]) -> FETCH.
//    - HALT: halted=1; start=1 -> START; otherwise stays.
//  - start is ignored outside IDLE/HALT.
// TESTING
//  1. rst, then start high 2 cycles then low -> done 1->0, START, FETCH; ir_we one pulse.
//  2. MEM_HS=1, ir=0x40 (ADD), FETCH mem_ready after 3 cycles -> mem_req 4 cycles, ir_we/pc_inc in 4th only.
//     Then OPFETCH, LDOPS, EXEC(op00, czn_we), WB(acc_we).
//  3. ir=0xC4 (JZ): czn=010 -> pc_ld=1 in BRANCH; czn=101 -> pc_ld=0; FETCH..BRANCH = 4 cycles zero-wait.
//  4. ACC_SEL_W=2, ir=0xA2 (SUB acc2) -> RDREG acc_sel=2, a_we, b_we; EXEC op01, czn_we; WB acc_we.
//  5. ir=0x20 (STA), rst during WB wait -> mem_req, mem_we to 0 same cycle, done=1; next start runs cleanly.
//  6. ir=0xE1 -> HALT, halted=1, busy=0 for 10 cycles; start pulse -> START then FETCH.

Source files
------------

// File: rtl/mc_accum_ctrl_hs.sv
// Multi-cycle controller for the 8-bit accumulator CPU: decodes ir/czn, sequences
// fetch/operand/execute/writeback with a req/ready memory handshake, and drives all datapath enables.
module mc_accum_ctrl_hs #(
    parameter int ACC_SEL_W = 2,
    parameter bit MEM_HS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           ir,
    input  logic [2:0]           czn,
    input  logic                 mem_ready,
    output logic                 done,
    output logic                 busy,
    output logic                 halted,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 pc_inc,
    output logic                 pc_ld,
    output logic                 ir_we,
    output logic                 tr_we,
    output logic                 a_we,
    output logic                 b_we,
    output logic                 a_zero,
    output logic                 b_zero,
    output logic [1:0]           alu_op,
    output logic                 alu_we,
    output logic                 czn_we,
    output logic                 acc_we,
    output logic [ACC_SEL_W-1:0] acc_sel
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_FETCH, S_DECODE, S_OPFETCH, S_LDOPS,
        S_RDREG, S_EXEC, S_WB, S_BRANCH, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic       is_mem, is_reg, is_jmp, is_halt, is_sta;
    logic [1:0] mop, rop;
    logic       mem_ok, jmp_take;
    logic       unused_ir;

    assign is_mem    = ~ir[7];
    assign is_reg    = (ir[7:6] == 2'b10);
    assign is_jmp    = (ir[7:5] == 3'b110);
    assign is_halt   = (ir[7:5] == 3'b111) && ir[0];
    assign mop       = ir[6:5];
    assign rop       = ir[5:4];
    assign is_sta    = is_mem && (mop == 2'b01);
    assign unused_ir = ir[3];

    // Without the handshake every access completes in its first cycle.
    assign mem_ok = mem_ready || !MEM_HS;

    always_comb begin
        case (ir[2:1])
            2'b00:   jmp_take = 1'b1;
            2'b01:   jmp_take = czn[2];
            2'b10:   jmp_take = czn[1];
            default: jmp_take = czn[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        ir_we     = 1'b0;
        tr_we     = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        a_zero    = 1'b0;
        b_zero    = 1'b0;
        alu_op    = 2'b00;
        alu_we    = 1'b0;
        czn_we    = 1'b0;
        acc_we    = 1'b0;
        acc_sel   = '0;
        case (state)
            S_IDLE: begin
                done = 1'b1;
                if (start) state_nxt = S_START;
            end
            S_START: begin
                busy = 1'b1;
                if (!start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ok) begin
                    ir_we     = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                if (is_mem || is_jmp) state_nxt = S_OPFETCH;
                else if (is_reg)      state_nxt = S_RDREG;
                else if (is_halt)     state_nxt = S_HALT;
                else                  state_nxt = S_FETCH;
            end
            S_OPFETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ok) begin
                    tr_we     = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = is_jmp ? S_BRANCH : S_LDOPS;
                end
            end
            S_LDOPS: begin
                busy = 1'b1;
                b_we = 1'b1;
                if (is_sta) begin
                    state_nxt = S_EXEC;
                end else begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ok) begin
                        a_we      = 1'b1;
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_RDREG: begin
                busy      = 1'b1;
                acc_sel   = ir[ACC_SEL_W-1:0];
                a_we      = 1'b1;
                b_we      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                alu_we    = 1'b1;
                state_nxt = S_WB;
                if (is_reg) begin
                    case (rop)
                        2'b00:   b_zero = 1'b1;
                        2'b01:   czn_we = 1'b1;
                        2'b10:   begin alu_op = 2'b01; czn_we = 1'b1; end
                        default: begin alu_op = 2'b10; czn_we = 1'b1; end
                    endcase
                end else begin
                    case (mop)
                        2'b00:   begin b_zero = 1'b1; czn_we = 1'b1; end
                        2'b01:   a_zero = 1'b1;
                        2'b10:   czn_we = 1'b1;
                        default: begin alu_op = 2'b01; czn_we = 1'b1; end
                    endcase
                end
            end
            S_WB: begin
                busy = 1'b1;
                if (is_sta) begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ok) state_nxt = S_FETCH;
                end else begin
                    acc_we    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_BRANCH: begin
                busy      = 1'b1;
                pc_ld     = jmp_take;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) state_nxt = S_START;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_accum_ctrl_hs.sv
// Randomized bench for mc_accum_ctrl_hs: each instruction is expanded into its expected
// micro-step list (outputs while waiting / on accept) and compared cycle by cycle.
module tb_mc_accum_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst, start, mem_ready;
    logic [7:0] ir;
    logic [2:0] czn;
    logic       done, busy, halted, mem_req, mem_we, addr_sel, pc_inc, pc_ld;
    logic       ir_we, tr_we, a_we, b_we, a_zero, b_zero, alu_we, czn_we, acc_we;
    logic [1:0] alu_op;
    logic [1:0] acc_sel;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mc_accum_ctrl_hs #(.ACC_SEL_W(2), .MEM_HS(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .czn(czn), .mem_ready(mem_ready),
        .done(done), .busy(busy), .halted(halted), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .pc_inc(pc_inc), .pc_ld(pc_ld), .ir_we(ir_we), .tr_we(tr_we),
        .a_we(a_we), .b_we(b_we), .a_zero(a_zero), .b_zero(b_zero), .alu_op(alu_op),
        .alu_we(alu_we), .czn_we(czn_we), .acc_we(acc_we), .acc_sel(acc_sel)
    );

    logic [20:0] obs;
    assign obs = {done, busy, halted, mem_req, mem_we, addr_sel, pc_inc, pc_ld, ir_we, tr_we,
                  a_we, b_we, a_zero, b_zero, alu_op, alu_we, czn_we, acc_we, acc_sel};

    localparam logic [20:0] M_DONE  = 21'h100000;
    localparam logic [20:0] M_BUSY  = 21'h080000;
    localparam logic [20:0] M_HALT  = 21'h040000;
    localparam logic [20:0] M_MREQ  = 21'h020000;
    localparam logic [20:0] M_MWE   = 21'h010000;
    localparam logic [20:0] M_ASEL  = 21'h008000;
    localparam logic [20:0] M_PCINC = 21'h004000;
    localparam logic [20:0] M_PCLD  = 21'h002000;
    localparam logic [20:0] M_IRWE  = 21'h001000;
    localparam logic [20:0] M_TRWE  = 21'h000800;
    localparam logic [20:0] M_AWE   = 21'h000400;
    localparam logic [20:0] M_BWE   = 21'h000200;
    localparam logic [20:0] M_AZ    = 21'h000100;
    localparam logic [20:0] M_BZ    = 21'h000080;
    localparam logic [20:0] M_OP1   = 21'h000040;
    localparam logic [20:0] M_OP0   = 21'h000020;
    localparam logic [20:0] M_ALUWE = 21'h000010;
    localparam logic [20:0] M_CZNWE = 21'h000008;
    localparam logic [20:0] M_ACCWE = 21'h000004;

    typedef struct packed {
        logic [20:0] base;
        logic [20:0] acc;
        logic        mem;
    } phase_t;

    phase_t exp_q[$];

    function automatic void push(input logic [20:0] b, input logic [20:0] a, input logic m);
        phase_t p;
        p.base = b;
        p.acc  = a;
        p.mem  = m;
        exp_q.push_back(p);
    endfunction

    // Expected micro-steps of one instruction, starting at its fetch.
    function automatic void build(input logic [7:0] i, input logic [2:0] f);
        logic [20:0] ex;
        logic        take;
        exp_q.delete();
        push(M_BUSY | M_MREQ, M_IRWE | M_PCINC, 1'b1);
        push(M_BUSY, 21'd0, 1'b0);
        if (i[7] == 1'b0) begin
            push(M_BUSY | M_MREQ, M_TRWE | M_PCINC, 1'b1);
            if (i[6:5] == 2'b01) push(M_BUSY | M_BWE, 21'd0, 1'b0);
            else                 push(M_BUSY | M_BWE | M_MREQ | M_ASEL, M_AWE, 1'b1);
            case (i[6:5])
                2'b00:   ex = M_BZ | M_CZNWE;
                2'b01:   ex = M_AZ;
                2'b10:   ex = M_CZNWE;
                default: ex = M_OP0 | M_CZNWE;
            endcase
            push(M_BUSY | M_ALUWE | ex, 21'd0, 1'b0);
            if (i[6:5] == 2'b01) push(M_BUSY | M_MREQ | M_MWE | M_ASEL, 21'd0, 1'b1);
            else                 push(M_BUSY | M_ACCWE, 21'd0, 1'b0);
        end else if (i[6] == 1'b0) begin
            push(M_BUSY | M_AWE | M_BWE | {19'd0, i[1:0]}, 21'd0, 1'b0);
            case (i[5:4])
                2'b00:   ex = M_BZ;
                2'b01:   ex = M_CZNWE;
                2'b10:   ex = M_OP0 | M_CZNWE;
                default: ex = M_OP1 | M_CZNWE;
            endcase
            push(M_BUSY | M_ALUWE | ex, 21'd0, 1'b0);
            push(M_BUSY | M_ACCWE, 21'd0, 1'b0);
        end else if (i[5] == 1'b0) begin
            push(M_BUSY | M_MREQ, M_TRWE | M_PCINC, 1'b1);
            case (i[2:1])
                2'b00:   take = 1'b1;
                2'b01:   take = f[2];
                2'b10:   take = f[1];
                default: take = f[0];
            endcase
            push(M_BUSY | (take ? M_PCLD : 21'd0), 21'd0, 1'b0);
        end
    endfunction

    // Entered at posedge+1; leaves at posedge+1 after the step completes.
    task automatic do_phase(input phase_t p, input int waits, input string tag);
        int w;
        w = p.mem ? waits : 0;
        for (int c = 0; c <= w; c++) begin
            logic [20:0] e;
            mem_ready = p.mem ? (c == w) : 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            e         = (c == w) ? (p.base | p.acc) : p.base;
            @(negedge clk);
            checks++;
            if (obs !== e) $display("FAIL %s cyc%0d: got %h want %h", tag, c, obs, e);
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input logic [7:0] i, input logic [2:0] f, input int fetch_wait,
                             input bit rnd, input int keep_last, input string tag);
        int n, wt;
        ir  = i;
        czn = f;
        build(i, f);
        n = exp_q.size() - keep_last;
        for (int k = 0; k < n; k++) begin
            if (k == 0) wt = fetch_wait;
            else        wt = rnd ? int'($urandom_range(0, 3)) : 0;
            do_phase(exp_q[k], wt, $sformatf("%s ir=%h step%0d", tag, i, k));
        end
    endtask

    // From IDLE (or HALT) at posedge+1: start high two cycles, then low; ends in FETCH.
    task automatic begin_run(input bit from_halt, input string tag);
        logic [20:0] idle_e;
        idle_e    = from_halt ? M_HALT : M_DONE;
        start     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== idle_e) $display("FAIL %s idle: got %h want %h", tag, obs, idle_e);
        else passes++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== M_BUSY) $display("FAIL %s start1: got %h want %h", tag, obs, M_BUSY);
        else passes++;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== M_BUSY) $display("FAIL %s start2: got %h want %h", tag, obs, M_BUSY);
        else passes++;
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] rand_instr();
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        if (r[7:5] == 3'b111) r[0] = 1'b0;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 8'h00; czn = 3'b000;
        #3;
        checks++;
        if (obs !== M_DONE) $display("FAIL reset_async: got %h want %h", obs, M_DONE);
        else passes++;
        start = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== M_DONE) $display("FAIL reset_held: got %h want %h", obs, M_DONE);
        else passes++;
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_start_fetch_wait();
        begin_run(1'b0, "start");
        run_instr(8'h40, 3'b000, 3, 1'b0, 0, "fetch_wait");
    endtask

    task automatic test_jump();
        run_instr(8'hC4, 3'b010, 0, 1'b0, 0, "jz_taken");
        run_instr(8'hC4, 3'b101, 0, 1'b0, 0, "jz_not");
        run_instr(8'hC0, 3'b000, 0, 1'b0, 0, "jmp_always");
        run_instr(8'hC2, 3'b100, 1, 1'b1, 0, "jc_taken");
    endtask

    task automatic test_regop();
        run_instr(8'hA2, 3'b000, 0, 1'b0, 0, "reg_sub");
        run_instr(8'h83, 3'b000, 0, 1'b0, 0, "reg_mov");
        run_instr(8'hB1, 3'b000, 0, 1'b0, 0, "reg_and");
    endtask

    task automatic test_sta_reset();
        run_instr(8'h20, 3'b000, 0, 1'b0, 1, "sta_rst");
        start     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== (M_BUSY | M_MREQ | M_MWE | M_ASEL))
            $display("FAIL sta_wb_wait: got %h want %h", obs, M_BUSY | M_MREQ | M_MWE | M_ASEL);
        else passes++;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== M_DONE) $display("FAIL sta_wb_rst: got %h want %h", obs, M_DONE);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        begin_run(1'b0, "restart");
        run_instr(8'h20, 3'b000, 0, 1'b1, 0, "sta_clean");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            run_instr(rand_instr(), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1, 0, "rand");
    endtask

    task automatic test_halt();
        run_instr(8'hE1, 3'b000, 0, 1'b0, 0, "halt");
        for (int c = 0; c < 10; c++) begin
            start     = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs !== M_HALT) $display("FAIL halt_hold cyc%0d: got %h want %h", c, obs, M_HALT);
            else passes++;
            @(posedge clk); #1;
        end
        begin_run(1'b1, "halt_restart");
        run_instr(8'hE0, 3'b000, 0, 1'b0, 0, "nop");
        run_instr(8'h00, 3'b000, 2, 1'b1, 0, "lda");
    endtask

    initial begin
        test_reset();
        test_start_fetch_wait();
        test_jump();
        test_regop();
        test_sta_reset();
        test_random();
        test_halt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
